mult_div_unit: RTL

//  Multi-cycle signed MULT/DIV engine for the multicycle MIPS datapath, directly downstream of the control unit.
//  The control unit decodes MULT/DIV (funct 011000/011010), pulses a start strobe and waits on done.
//  The unit writes the HI/LO pair consumed by MFHI/MFLO and flags divide-by-zero for the exception path.

---
 rtl/mult_div_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle signed MULT (radix-2 Booth) / DIV (restoring) engine writing HI/LO. Latency: start in cycle 0 -> done pulse in cycle WIDTH+1.
// No backpressure: starts are only sampled in IDLE, otherwise dropped. MDU_DIV0_EXC_EN enables the early divide-by-zero exit and div_zero flag.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] mreg;
    logic             q_m1;
    logic             a_neg;
    logic             b_neg;
    logic             last_step;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]   acc_x;
    logic [WIDTH:0]   m_x;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] booth_acc;
    logic [WIDTH-1:0] booth_q;

    logic [WIDTH:0]   shifted;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] div_hi;

    assign abs_a     = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b     = op_b[WIDTH-1] ? -op_b : op_b;
    assign last_step = (count == CW'(1));

    // Booth step at W+1 bits so the add/sub never loses the sign before the shift.
    always_comb begin
        acc_x = {acc[WIDTH-1], acc};
        m_x   = {mreg[WIDTH-1], mreg};
        case ({qreg[0], q_m1})
            2'b01:   booth_sum = acc_x + m_x;
            2'b10:   booth_sum = acc_x - m_x;
            default: booth_sum = acc_x;
        endcase
    end

    assign booth_acc = booth_sum[WIDTH:1];
    assign booth_q   = {booth_sum[0], qreg[WIDTH-1:1]};

    // Restoring step on magnitudes: acc holds the partial remainder, qreg shifts
    // the dividend out at the top and the quotient bits in at the bottom.
    assign shifted = {acc, qreg[WIDTH-1]};
    assign div_ge  = (shifted >= {1'b0, mreg});
    assign div_acc = div_ge ? (shifted[WIDTH-1:0] - mreg) : shifted[WIDTH-1:0];
    assign div_q   = {qreg[WIDTH-2:0], div_ge};
    assign quo_fix = (a_neg ^ b_neg) ? -div_q : div_q;
    assign rem_fix = a_neg ? -div_acc : div_acc;

`ifdef MDU_DIV0_EXC_EN
    logic div_zero_q;

    assign div_lo   = quo_fix;
    assign div_hi   = rem_fix;
    assign div_zero = div_zero_q;
`else
    logic [WIDTH-1:0] a_lat;

    // A zero divisor runs the full loop, then the result is overridden.
    assign div_lo   = (mreg == '0) ? '1 : quo_fix;
    assign div_hi   = (mreg == '0) ? a_lat : rem_fix;
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            count <= '0;
            acc   <= '0;
            qreg  <= '0;
            mreg  <= '0;
            q_m1  <= 1'b0;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MDU_DIV0_EXC_EN
            div_zero_q <= 1'b0;
`else
            a_lat <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MDU_DIV0_EXC_EN
            div_zero_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (mult_start) begin
                        state <= ST_MULT;
                        busy  <= 1'b1;
                        count <= CW'(WIDTH);
                        acc   <= '0;
                        qreg  <= op_b;
                        mreg  <= op_a;
                        q_m1  <= 1'b0;
                    end else if (div_start) begin
`ifdef MDU_DIV0_EXC_EN
                        if (op_b == '0) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            div_zero_q <= 1'b1;
                        end else begin
`else
                        begin
                            a_lat <= op_a;
`endif
                            state <= ST_DIV;
                            busy  <= 1'b1;
                            count <= CW'(WIDTH);
                            acc   <= '0;
                            qreg  <= abs_a;
                            mreg  <= abs_b;
                            a_neg <= op_a[WIDTH-1];
                            b_neg <= op_b[WIDTH-1];
                        end
                    end
                end
                ST_MULT: begin
                    acc   <= booth_acc;
                    qreg  <= booth_q;
                    q_m1  <= qreg[0];
                    count <= count - CW'(1);
                    if (last_step) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= booth_acc;
                        lo    <= booth_q;
                    end
                end
                ST_DIV: begin
                    acc   <= div_acc;
                    qreg  <= div_q;
                    count <= count - CW'(1);
                    if (last_step) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= div_hi;
                        lo    <= div_lo;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
